sigmacore_dmem_responder: RTL and testbench
===========================================

SIGMACORE_DMEM_RESPONDER -- requirements
Module: sigmacore_dmem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hCAFEF000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to rsp_valid (range 1..15).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  CPU presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, little-endian lanes.
REQ-011 req_be  input  4  byte enables for stores; ignored for loads.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  CPU accepts response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access fault (out of range or misaligned).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE req_ready SHALL be 1; in WAIT and RESP req_ready SHALL be 0 (one outstanding request).
REQ-018 A request SHALL be accepted when req_valid && req_ready on a rising edge; all req_* fields latched that edge; state -> WAIT, latency counter loaded with LATENCY-1.
REQ-019 In WAIT counter SHALL decrement each cycle; when counter is 0, state -> RESP next edge, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 In RESP rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid && rsp_ready; on that edge state -> IDLE.
REQ-021 Back-to-back: new request SHALL NOT be accepted on the same edge the response handshakes; earliest accept is the following edge (req_ready high in IDLE).
REQ-022 Word index = (req_addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction (wrap-around below BASE_ADDR yields out of range).
REQ-023 Error SHALL be flagged when req_addr[1:0] != 0 or index >= DEPTH_WORDS; errored store SHALL NOT modify memory; errored load returns rsp_rdata = 0.
REQ-024 Store SHALL write only enabled byte lanes (be[i] -> bits 8i+7:8i) on the edge entering RESP; rsp_rdata = 0, rsp_err = 0.
REQ-025 Store with req_be = 4'b0000 SHALL complete normally with no memory change.
REQ-026 Load SHALL return word contents sampled on the edge entering RESP (reflects all prior completed stores).
REQ-027 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata, rsp_err SHALL be 0.
REQ-028 req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-029 reset SHALL force state IDLE, counter 0, req_ready 1 (first edge after reset deasserts), rsp_valid 0, rsp_rdata 0, rsp_err 0, latched request cleared.
REQ-030 Reset mid-WAIT or mid-RESP SHALL abandon the transaction; a pending store not yet committed SHALL NOT write memory.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 Shared package sigmacore_pkg SHALL hold typedef dmem_state_t (IDLE/WAIT/RESP) and constant DMEM_BASE_ADDR = 32'hCAFEF000.
REQ-033 Storage SHALL be a sub-module sigmacore_dmem_array (single-port, byte-enable write, synchronous read); FSM and decode in the top module.

Verification
REQ-034 Store 0x95FDE100 to 0xCAFEF00C, be=4'hF, LATENCY=2 -> rsp_valid exactly 2 cycles after accept, rsp_err=0; then load 0xCAFEF00C -> rsp_rdata=0x95FDE100.
REQ-035 Store 0xAABBCCDD be=4'b0101 over word 0x11223344 at 0xCAFEF000 -> load returns 0x11BB33DD.
REQ-036 Load 0xCAFEF002 (misaligned) and 0xCAFEF000+4*DEPTH_WORDS and 0xCAFEEFFC -> rsp_err=1, rsp_rdata=0; store to same addresses leaves memory unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; second request held valid is accepted only the edge after the handshake.
REQ-038 Assert reset during WAIT of a store to 0xCAFEF010 -> outputs return to reset values next edge, subsequent load of 0xCAFEF010 returns prior contents.

Source files
------------

// File: rtl/sigmacore_pkg.sv
// Shared sigmacore types and constants for the data-memory responder.
//   dmem_state_t   : responder FSM states
//   dmem_req_t     : request fields captured at accept time
//   DMEM_BASE_ADDR : default byte address of data-memory word 0
package sigmacore_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'hCAFEF000;
    localparam int unsigned DMEM_LAT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

endpackage

// File: rtl/sigmacore_dmem_array.sv
// Single-port data-memory storage with byte-enable write and synchronous read.
//   clk, reset : clock; reset clears only the read register, never the array
//   en_i       : perform access this edge (write if we_i, else read)
//   clr_i      : zero the read register (response retired)
//   we_i, be_i : store strobe and byte-lane enables
//   addr_i     : word index
//   wdata_i    : store data, little-endian lanes
//   rdata_o    : registered read data; 0 after stores, clears and reset
module sigmacore_dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en_i,
    input  logic                           clr_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value until the next access or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? '0 : mem_q[addr_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sigmacore_dmem_responder.sv
// Data-memory responder: one outstanding load/store with fixed response latency.
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_we, req_addr     : store strobe and byte address
//   req_wdata, req_be    : store data and byte enables
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata, rsp_err   : load data and access fault; both 0 outside a response
module sigmacore_dmem_responder
    import sigmacore_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = DMEM_LAT_W;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;

    logic             mem_en_c;
    logic             mem_clr_c;
    logic [31:0]      offset_c;
    logic [31:0]      word_c;
    logic             dec_err_c;

    // Address decode; subtraction wraps so addresses below the base land out of range.
    always_comb begin
        offset_c  = req_addr - BASE_ADDR;
        word_c    = offset_c >> 2;
        dec_err_c = (req_addr[1:0] != 2'b00) || (word_c >= 32'(DEPTH_WORDS));
    end

    // State and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            idx_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic; memory is accessed only on the edge entering RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        mem_en_c    = 1'b0;
        mem_clr_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    req_d.we    = req_we;
                    req_d.err   = dec_err_c;
                    req_d.wdata = req_wdata;
                    req_d.be    = req_be;
                    idx_d       = word_c[IDX_W-1:0];
                    cnt_d       = CNT_W'(LATENCY - 1);
                    ready_d     = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    mem_en_c    = ~req_q.err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = req_q.err;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    mem_clr_c   = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Reset on the commit edge must cancel the pending store.
    sigmacore_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .en_i    (mem_en_c & ~reset),
        .clr_i   (mem_clr_c),
        .we_i    (req_q.we),
        .be_i    (req_q.be),
        .addr_i  (idx_q),
        .wdata_i (req_q.wdata),
        .rdata_o (rsp_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sigmacore_dmem_responder.sv
// Self-checking bench for sigmacore_dmem_responder against a word-array reference model.
module tb_sigmacore_dmem_responder;

    localparam logic [31:0] BASE  = 32'hCAFEF000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    sigmacore_dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    logic [31:0] model [DEPTH];
    int          n_chk  = 0;
    int          n_fail = 0;

    logic        p_we;
    logic        p_err;
    int          p_idx;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    logic [31:0] p_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || ((off / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_err"},   32'(rsp_err),   32'd0);
    endtask

    // Present a request, confirm it is taken, then scramble the request bus.
    task automatic start_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        p_we    = we;
        p_err   = addr_err(addr);
        p_idx   = p_err ? 0 : int'((addr - BASE) / 4);
        p_wdata = wdata;
        p_be    = be;
        p_exp   = (we || p_err) ? 32'd0 : model[p_idx];
        @(posedge clk); #1;
        chk("ready_after_accept", 32'(req_ready), 32'd0);
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
    endtask

    // Wait for the response, check it and commit the store to the model.
    task automatic wait_rsp();
        int lat;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        chk("latency",   32'(lat), 32'(LAT));
        chk("rsp_err",   32'(rsp_err), 32'(p_err));
        chk("rsp_rdata", rsp_rdata, p_exp);
        if (p_we && !p_err) model[p_idx] = merge(model[p_idx], p_wdata, p_be);
    endtask

    // Stall the response for `hold` cycles, then retire it.
    task automatic end_rsp(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, p_exp);
            chk("hold_err",   32'(rsp_err), 32'(p_err));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rdata", rsp_rdata, 32'd0);
        chk("idle_err",   32'(rsp_err), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
        start_req(we, addr, wdata, be);
        wait_rsp();
        end_rsp(hold);
    endtask

    // Reset a store in flight; `extra` idle WAIT cycles before reset (extra=LAT-1 hits the commit edge).
    task automatic reset_mid_store(input logic [31:0] addr, input int extra, input string tag);
        start_req(1'b1, addr, ~model[(addr - BASE) / 4], 4'hF);
        for (int i = 0; i < extra; i++) begin
            @(posedge clk); #1;
            chk({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_outputs(tag);
        repeat (3) begin
            @(posedge clk); #1;
            chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, addr, 32'd0, 4'h0, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;

        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
        end

        // Full-word store then load back.
        txn(1'b1, 32'hCAFEF00C, 32'h95FDE100, 4'hF, 0);
        start_req(1'b0, 32'hCAFEF00C, 32'd0, 4'h0);
        wait_rsp();
        chk("store_load_word", rsp_rdata, 32'h95FDE100);
        end_rsp(0);

        // Partial byte-lane store.
        txn(1'b1, 32'hCAFEF000, 32'h11223344, 4'hF, 0);
        txn(1'b1, 32'hCAFEF000, 32'hAABBCCDD, 4'b0101, 1);
        start_req(1'b0, 32'hCAFEF000, 32'd0, 4'h0);
        wait_rsp();
        chk("byte_lane_merge", rsp_rdata, 32'h11BB33DD);
        end_rsp(0);

        // Faulting loads and stores.
        txn(1'b0, 32'hCAFEF002, 32'd0, 4'h0, 0);
        chk("misaligned_err_cleared", 32'(rsp_err), 32'd0);
        start_req(1'b0, BASE + 32'(4 * DEPTH), 32'd0, 4'h0);
        wait_rsp();
        chk("past_end_err", 32'(rsp_err), 32'd1);
        end_rsp(0);
        start_req(1'b0, 32'hCAFEEFFC, 32'd0, 4'h0);
        wait_rsp();
        chk("below_base_err", 32'(rsp_err), 32'd1);
        chk("below_base_rdata", rsp_rdata, 32'd0);
        end_rsp(0);
        txn(1'b1, 32'hCAFEF002, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b1, BASE + 32'(4 * DEPTH), 32'hDEADBEEF, 4'hF, 0);
        txn(1'b1, 32'hCAFEEFFC, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, BASE, 32'd0, 4'h0, 0);
        txn(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0, 4'h0, 0);

        // Zero byte enables leave the word untouched.
        txn(1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0, 0);
        txn(1'b0, BASE + 32'h20, 32'd0, 4'h0, 0);

        // Stalled response with a second request waiting behind it.
        start_req(1'b0, 32'hCAFEF00C, 32'd0, 4'h0);
        wait_rsp();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = BASE;
        end_rsp(5);
        start_req(1'b0, BASE, 32'd0, 4'h0);
        wait_rsp();
        end_rsp(0);

        // Reset abandons pending stores, including on the commit edge.
        reset_mid_store(32'hCAFEF010, 0, "rst_wait");
        reset_mid_store(32'hCAFEF010, int'(LAT) - 1, "rst_commit");

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            a   = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            case (sel)
                0: a = a + 32'($urandom_range(1, 3));
                1: a = $urandom;
                2: a = BASE - 32'(4 * $urandom_range(1, 8));
                3: a = BASE + 32'(4 * (DEPTH + $urandom_range(0, 7)));
                default: ;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
